multicycle_control: RTL and testbench

- Main control FSM for the multi-cycle datapath; sits directly upstream of the ALU control decoder and drives its aluop1/aluop0 inputs.
- Decodes the 6-bit opcode latched in IR and sequences fetch, decode, execute, memory and writeback per instruction.
- Uses a req/ready handshake to a variable-latency unified memory.
- Includes a bounded wait counter that aborts a stalled access.

---
 rtl/mc_pkg.sv | 68 ++++++
 rtl/multicycle_control.sv | 203 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle main control FSM and the downstream ALU control decoder.
package mc_pkg;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpBez   = 6'b000100;
  localparam logic [5:0] OpBgez  = 6'b000101;
  localparam logic [5:0] OpJm    = 6'b010010;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMaddr  = 4'd2,
    StMread  = 4'd3,
    StMwb    = 4'd4,
    StMwrite = 4'd5,
    StRexe   = 4'd6,
    StRwb    = 4'd7,
    StBranch = 4'd8,
    StAexe   = 4'd9,
    StAwb    = 4'd10,
    StJread  = 4'd11,
    StJpc    = 4'd12,
    StIll    = 4'd13
  } state_e;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpRtype = 2'b10;
  localparam logic [1:0] AluOpAndi  = 2'b11;

  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcMdr    = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       br_ge;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       zero_ext;
    logic       illegal_op;
  } ctrl_t;

  // States that hold a request open to the unified memory.
  function automatic logic is_mem_state(state_e s);
    return (s == StFetch) || (s == StMread) || (s == StMwrite) || (s == StJread);
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle datapath: fetch/decode/execute sequencing, memory
// handshake with a bounded wait, and the aluop class feeding the ALU control decoder.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 255,
  parameter int unsigned CW         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       br_ge,
  output logic [1:0] pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       aluop1,
  output logic       aluop0,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       zero_ext,
  output logic [3:0] state,
  output logic       illegal_op,
  output logic       mem_timeout
);

  localparam logic [CW-1:0] LastWait = CW'(WAIT_LIMIT - 1);

  state_e        state_q, state_d;
  logic          run_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
  logic          abort;
  ctrl_t         c, c_out;

  // The WAIT_LIMIT-th idle cycle of a memory state is the last one allowed.
  assign abort = is_mem_state(state_q) && !mem_ready && (cnt_q == LastWait);

  always_comb begin
    c         = '0;
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      StFetch: begin
        c.mem_req   = 1'b1;
        c.mem_read  = 1'b1;
        c.alu_src_b = SrcBFour;
        c.aluop     = AluOpAdd;
        if (mem_ready) begin
          c.ir_write = 1'b1;
          c.pc_write = 1'b1;
          state_d    = StDecode;
        end
      end
      StDecode: begin
        c.alu_src_b = SrcBImmSh;
        c.aluop     = AluOpAdd;
        case (op)
          OpLw, OpSw, OpJm: state_d = StMaddr;
          OpRtype:          state_d = StRexe;
          OpAndi:           state_d = StAexe;
          OpBez, OpBgez:    state_d = StBranch;
          default:          state_d = StIll;
        endcase
      end
      StMaddr: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SrcBImm;
        c.aluop     = AluOpAdd;
        case (op)
          OpLw:    state_d = StMread;
          OpSw:    state_d = StMwrite;
          OpJm:    state_d = StJread;
          default: state_d = StFetch;
        endcase
      end
      StMread, StJread: begin
        c.mem_req  = 1'b1;
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
        if (mem_ready) state_d = (state_q == StMread) ? StMwb : StJpc;
      end
      StMwrite: begin
        c.mem_req   = 1'b1;
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
        if (mem_ready) state_d = StFetch;
      end
      StMwb: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        state_d      = StFetch;
      end
      StJpc: begin
        c.pc_write  = 1'b1;
        c.pc_source = PcSrcMdr;
        state_d     = StFetch;
      end
      StRexe: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SrcBReg;
        c.aluop     = AluOpRtype;
        state_d     = StRwb;
      end
      StRwb: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        c.aluop     = AluOpRtype;
        state_d     = StFetch;
      end
      StAexe: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SrcBImm;
        c.zero_ext  = 1'b1;
        c.aluop     = AluOpAndi;
        state_d     = StAwb;
      end
      StAwb: begin
        c.reg_write = 1'b1;
        c.zero_ext  = 1'b1;
        c.aluop     = AluOpAndi;
        state_d     = StFetch;
      end
      StBranch: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SrcBReg;
        c.aluop         = AluOpSub;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PcSrcAluOut;
        c.br_ge         = op[0];
        state_d         = StFetch;
      end
      StIll: begin
        c.illegal_op = 1'b1;
        state_d      = StFetch;
      end
      default: state_d = StFetch;
    endcase

    if (is_mem_state(state_q) && !mem_ready) begin
      if (abort) begin
        timeout_d = 1'b1;
        state_d   = StFetch;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // A timed-out FETCH re-enters itself, so it restarts the count as well.
    if (is_mem_state(state_d) && ((state_d != state_q) || abort)) cnt_d = '0;

    if (!run_q) begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      run_q     <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign c_out         = run_q ? c : '0;
  assign mem_req       = c_out.mem_req;
  assign mem_read      = c_out.mem_read;
  assign mem_write     = c_out.mem_write;
  assign i_or_d        = c_out.i_or_d;
  assign ir_write      = c_out.ir_write;
  assign pc_write      = c_out.pc_write;
  assign pc_write_cond = c_out.pc_write_cond;
  assign br_ge         = c_out.br_ge;
  assign pc_source     = c_out.pc_source;
  assign alu_src_a     = c_out.alu_src_a;
  assign alu_src_b     = c_out.alu_src_b;
  assign aluop1        = c_out.aluop[1];
  assign aluop0        = c_out.aluop[0];
  assign reg_dst       = c_out.reg_dst;
  assign reg_write     = c_out.reg_write;
  assign mem_to_reg    = c_out.mem_to_reg;
  assign zero_ext      = c_out.zero_ext;
  assign illegal_op    = c_out.illegal_op;
  assign state         = run_q ? state_q : 4'd0;
  assign mem_timeout   = run_q & timeout_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle state and output vectors for each instruction
// class, plus a short-limit instance for the wait-counter abort.
module tb_multicycle_control;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_BEZ  = 6'b000100;
  localparam logic [5:0] OP_BGEZ = 6'b000101;
  localparam logic [5:0] OP_JM   = 6'b010010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  // Fields: req rd wr iord irw pcw pcwc brge | pcsrc | srca | srcb | aluop | dst rw m2r zx ill to
  localparam logic [20:0] E_FETCH_W  = {8'b1100_0000, 2'b00, 1'b0, 2'b01, 2'b00, 6'b000000};
  localparam logic [20:0] E_FETCH_GO = {8'b1100_1100, 2'b00, 1'b0, 2'b01, 2'b00, 6'b000000};
  localparam logic [20:0] E_DECODE   = {8'b0000_0000, 2'b00, 1'b0, 2'b11, 2'b00, 6'b000000};
  localparam logic [20:0] E_MADDR    = {8'b0000_0000, 2'b00, 1'b1, 2'b10, 2'b00, 6'b000000};
  localparam logic [20:0] E_MREAD    = {8'b1101_0000, 2'b00, 1'b0, 2'b00, 2'b00, 6'b000000};
  localparam logic [20:0] E_MWRITE   = {8'b1011_0000, 2'b00, 1'b0, 2'b00, 2'b00, 6'b000000};
  localparam logic [20:0] E_MWB      = {8'b0000_0000, 2'b00, 1'b0, 2'b00, 2'b00, 6'b011000};
  localparam logic [20:0] E_REXE     = {8'b0000_0000, 2'b00, 1'b1, 2'b00, 2'b10, 6'b000000};
  localparam logic [20:0] E_RWB      = {8'b0000_0000, 2'b00, 1'b0, 2'b00, 2'b10, 6'b110000};
  localparam logic [20:0] E_AEXE     = {8'b0000_0000, 2'b00, 1'b1, 2'b10, 2'b11, 6'b000100};
  localparam logic [20:0] E_AWB      = {8'b0000_0000, 2'b00, 1'b0, 2'b00, 2'b11, 6'b010100};
  localparam logic [20:0] E_BEZ      = {8'b0000_0010, 2'b01, 1'b1, 2'b00, 2'b01, 6'b000000};
  localparam logic [20:0] E_BGEZ     = {8'b0000_0011, 2'b01, 1'b1, 2'b00, 2'b01, 6'b000000};
  localparam logic [20:0] E_JPC      = {8'b0000_0100, 2'b10, 1'b0, 2'b00, 2'b00, 6'b000000};
  localparam logic [20:0] E_ILL      = {8'b0000_0000, 2'b00, 1'b0, 2'b00, 2'b00, 6'b000010};
  localparam logic [20:0] E_TO       = 21'd1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic       rst_n, mem_ready;
  logic [5:0] op;
  logic mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, br_ge;
  logic alu_src_a, aluop1, aluop0, reg_dst, reg_write, mem_to_reg, zero_ext, illegal_op;
  logic mem_timeout;
  logic [1:0] pc_source, alu_src_b;
  logic [3:0] state;
  logic [20:0] outs;

  logic       rst2_n, rdy2;
  logic [5:0] op2;
  logic m2_req, m2_read, m2_write, m2_iord, m2_irw, m2_pcw, m2_pcwc, m2_brge;
  logic m2_srca, m2_a1, m2_a0, m2_dst, m2_rw, m2_m2r, m2_zx, m2_ill, m2_to;
  logic [1:0] m2_pcsrc, m2_srcb;
  logic [3:0] state2;
  logic [20:0] outs2;

  assign outs = {mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, br_ge,
                 pc_source, alu_src_a, alu_src_b, aluop1, aluop0, reg_dst, reg_write, mem_to_reg,
                 zero_ext, illegal_op, mem_timeout};
  assign outs2 = {m2_req, m2_read, m2_write, m2_iord, m2_irw, m2_pcw, m2_pcwc, m2_brge,
                  m2_pcsrc, m2_srca, m2_srcb, m2_a1, m2_a0, m2_dst, m2_rw, m2_m2r,
                  m2_zx, m2_ill, m2_to};

  multicycle_control u_dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond), .br_ge(br_ge),
    .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .aluop1(aluop1), .aluop0(aluop0), .reg_dst(reg_dst), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .zero_ext(zero_ext), .state(state),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );

  multicycle_control #(.WAIT_LIMIT(4), .CW(3)) u_dut_short (
    .clk(clk), .rst_n(rst2_n), .op(op2), .mem_ready(rdy2),
    .mem_req(m2_req), .mem_read(m2_read), .mem_write(m2_write), .i_or_d(m2_iord),
    .ir_write(m2_irw), .pc_write(m2_pcw), .pc_write_cond(m2_pcwc), .br_ge(m2_brge),
    .pc_source(m2_pcsrc), .alu_src_a(m2_srca), .alu_src_b(m2_srcb),
    .aluop1(m2_a1), .aluop0(m2_a0), .reg_dst(m2_dst), .reg_write(m2_rw),
    .mem_to_reg(m2_m2r), .zero_ext(m2_zx), .state(state2),
    .illegal_op(m2_ill), .mem_timeout(m2_to)
  );

  task automatic test_reset();
    op = OP_LW; mem_ready = 1'b1; rst_n = 1'b0;
    @(posedge clk); #2;
    for (int i = 0; i < 3; i++) begin
      #1; tests_run++;
      if ({state, outs} !== 25'd0) begin
        tests_failed++;
        $display("FAIL reset_hold cyc %0d: got state=%0d outs=%h, want 0/0", i, state, outs);
      end
      @(posedge clk); #2;
    end
    rst_n = 1'b1; #1; tests_run++;
    if ({state, outs} !== 25'd0) begin
      tests_failed++;
      $display("FAIL reset_release: got state=%0d outs=%h, want 0/0", state, outs);
    end
    @(posedge clk); #2; #1; tests_run++;
    if ({state, outs} !== {4'd0, E_FETCH_GO}) begin
      tests_failed++;
      $display("FAIL first_fetch: got state=%0d outs=%h, want 0/%h", state, outs, E_FETCH_GO);
    end
    @(posedge clk); #2; #1; tests_run++;
    if ({state, outs} !== {4'd1, E_DECODE}) begin
      tests_failed++;
      $display("FAIL first_decode: got state=%0d outs=%h, want 1/%h", state, outs, E_DECODE);
    end
    rst_n = 1'b0; #1; tests_run++;
    if ({state, outs} !== 25'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_instr: got state=%0d outs=%h, want 0/0", state, outs);
    end
    @(posedge clk); #2; rst_n = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic test_lw();
    logic [31:0] seq [6];
    seq = '{{OP_LW, 1'b1, 4'd0, E_FETCH_GO}, {OP_LW, 1'b1, 4'd1, E_DECODE},
            {OP_LW, 1'b1, 4'd2, E_MADDR},    {OP_LW, 1'b1, 4'd3, E_MREAD},
            {OP_LW, 1'b1, 4'd4, E_MWB},      {OP_LW, 1'b0, 4'd0, E_FETCH_W}};
    for (int i = 0; i < 6; i++) begin
      op = seq[i][31:26]; mem_ready = seq[i][25]; #1; tests_run++;
      if ({state, outs} !== seq[i][24:0]) begin
        tests_failed++;
        $display("FAIL lw step %0d: got state=%0d outs=%h, want %0d/%h",
                 i, state, outs, seq[i][24:21], seq[i][20:0]);
      end
      @(posedge clk); #2;
    end
  endtask

  task automatic test_sw_stall();
    logic [31:0] seq [10];
    seq = '{{OP_SW, 1'b1, 4'd0, E_FETCH_GO}, {OP_SW, 1'b0, 4'd1, E_DECODE},
            {OP_SW, 1'b0, 4'd2, E_MADDR},    {OP_SW, 1'b0, 4'd5, E_MWRITE},
            {OP_SW, 1'b0, 4'd5, E_MWRITE},   {OP_SW, 1'b0, 4'd5, E_MWRITE},
            {OP_SW, 1'b0, 4'd5, E_MWRITE},   {OP_SW, 1'b0, 4'd5, E_MWRITE},
            {OP_SW, 1'b1, 4'd5, E_MWRITE},   {OP_SW, 1'b0, 4'd0, E_FETCH_W}};
    for (int i = 0; i < 10; i++) begin
      op = seq[i][31:26]; mem_ready = seq[i][25]; #1; tests_run++;
      if ({state, outs} !== seq[i][24:0]) begin
        tests_failed++;
        $display("FAIL sw_stall step %0d: got state=%0d outs=%h, want %0d/%h",
                 i, state, outs, seq[i][24:21], seq[i][20:0]);
      end
      @(posedge clk); #2;
    end
  endtask

  task automatic test_rtype_andi();
    logic [31:0] seq [8];
    seq = '{{OP_R, 1'b1, 4'd0, E_FETCH_GO},    {OP_R, 1'b1, 4'd1, E_DECODE},
            {OP_R, 1'b1, 4'd6, E_REXE},        {OP_R, 1'b1, 4'd7, E_RWB},
            {OP_ANDI, 1'b1, 4'd0, E_FETCH_GO}, {OP_ANDI, 1'b1, 4'd1, E_DECODE},
            {OP_ANDI, 1'b1, 4'd9, E_AEXE},     {OP_ANDI, 1'b1, 4'd10, E_AWB}};
    for (int i = 0; i < 8; i++) begin
      op = seq[i][31:26]; mem_ready = seq[i][25]; #1; tests_run++;
      if ({state, outs} !== seq[i][24:0]) begin
        tests_failed++;
        $display("FAIL rtype_andi step %0d: got state=%0d outs=%h, want %0d/%h",
                 i, state, outs, seq[i][24:21], seq[i][20:0]);
      end
      @(posedge clk); #2;
    end
  endtask

  task automatic test_branch();
    logic [31:0] seq [6];
    seq = '{{OP_BGEZ, 1'b1, 4'd0, E_FETCH_GO}, {OP_BGEZ, 1'b1, 4'd1, E_DECODE},
            {OP_BGEZ, 1'b1, 4'd8, E_BGEZ},     {OP_BEZ, 1'b1, 4'd0, E_FETCH_GO},
            {OP_BEZ, 1'b1, 4'd1, E_DECODE},    {OP_BEZ, 1'b1, 4'd8, E_BEZ}};
    for (int i = 0; i < 6; i++) begin
      op = seq[i][31:26]; mem_ready = seq[i][25]; #1; tests_run++;
      if ({state, outs} !== seq[i][24:0]) begin
        tests_failed++;
        $display("FAIL branch step %0d: got state=%0d outs=%h, want %0d/%h",
                 i, state, outs, seq[i][24:21], seq[i][20:0]);
      end
      @(posedge clk); #2;
    end
  endtask

  task automatic test_jm();
    logic [31:0] seq [7];
    seq = '{{OP_JM, 1'b0, 4'd0, E_FETCH_W},  {OP_JM, 1'b1, 4'd0, E_FETCH_GO},
            {OP_JM, 1'b1, 4'd1, E_DECODE},   {OP_JM, 1'b1, 4'd2, E_MADDR},
            {OP_JM, 1'b0, 4'd11, E_MREAD},   {OP_JM, 1'b1, 4'd11, E_MREAD},
            {OP_JM, 1'b1, 4'd12, E_JPC}};
    for (int i = 0; i < 7; i++) begin
      op = seq[i][31:26]; mem_ready = seq[i][25]; #1; tests_run++;
      if ({state, outs} !== seq[i][24:0]) begin
        tests_failed++;
        $display("FAIL jm step %0d: got state=%0d outs=%h, want %0d/%h",
                 i, state, outs, seq[i][24:21], seq[i][20:0]);
      end
      @(posedge clk); #2;
    end
  endtask

  task automatic test_illegal();
    logic [31:0] seq [4];
    seq = '{{OP_BAD, 1'b1, 4'd0, E_FETCH_GO}, {OP_BAD, 1'b1, 4'd1, E_DECODE},
            {OP_BAD, 1'b1, 4'd13, E_ILL},     {OP_BAD, 1'b0, 4'd0, E_FETCH_W}};
    for (int i = 0; i < 4; i++) begin
      op = seq[i][31:26]; mem_ready = seq[i][25]; #1; tests_run++;
      if ({state, outs} !== seq[i][24:0]) begin
        tests_failed++;
        $display("FAIL illegal step %0d: got state=%0d outs=%h, want %0d/%h",
                 i, state, outs, seq[i][24:21], seq[i][20:0]);
      end
      @(posedge clk); #2;
    end
  endtask

  // Four idle FETCH cycles abort; the retry then succeeds exactly on its limit cycle.
  task automatic test_timeout();
    logic [31:0] seq [9];
    seq = '{{OP_LW, 1'b0, 4'd0, E_FETCH_W},         {OP_LW, 1'b0, 4'd0, E_FETCH_W},
            {OP_LW, 1'b0, 4'd0, E_FETCH_W},         {OP_LW, 1'b0, 4'd0, E_FETCH_W},
            {OP_LW, 1'b0, 4'd0, E_FETCH_W | E_TO},  {OP_LW, 1'b0, 4'd0, E_FETCH_W | E_TO},
            {OP_LW, 1'b0, 4'd0, E_FETCH_W | E_TO},  {OP_LW, 1'b1, 4'd0, E_FETCH_GO | E_TO},
            {OP_LW, 1'b0, 4'd1, E_DECODE | E_TO}};
    op2 = OP_LW; rdy2 = 1'b0; rst2_n = 1'b1;
    @(posedge clk); #2;
    for (int i = 0; i < 9; i++) begin
      op2 = seq[i][31:26]; rdy2 = seq[i][25]; #1; tests_run++;
      if ({state2, outs2} !== seq[i][24:0]) begin
        tests_failed++;
        $display("FAIL timeout step %0d: got state=%0d outs=%h, want %0d/%h",
                 i, state2, outs2, seq[i][24:21], seq[i][20:0]);
      end
      @(posedge clk); #2;
    end
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    op = '0; op2 = '0; mem_ready = 1'b0; rdy2 = 1'b0;
    test_reset();
    test_lw();
    test_sw_stall();
    test_rtype_andi();
    test_branch();
    test_jm();
    test_illegal();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
